// File: rtl/imem_loader_rom_if.sv
// ---------------------------------------------------------------------------
// imem_loader_rom_if
// Purpose : bundles the fetch port and the byte-serial loader port of
//           imem_loader_rom into one interface.
// Signals : PC        fetch address                    (master -> slave)
//           instr     instruction for PC, combinational (slave -> master)
//           ld_start  pulse: begin program load         (master -> slave)
//           ld_valid  loader byte valid                 (master -> slave)
//           ld_data   loader byte, MSB-first in a word  (master -> slave)
//           ld_last   final byte of the image           (master -> slave)
//           ld_ready  loader may present a byte         (slave -> master)
//           core_rst  active-low reset to the core      (slave -> master)
//           prog_len  words written by last load        (slave -> master)
//           ld_ovf    sticky image-overflow flag        (slave -> master)
// ---------------------------------------------------------------------------
interface imem_loader_rom_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
);
    logic [ADDR_W-1:0]  PC;
    logic [INSTR_W-1:0] instr;
    logic               ld_start;
    logic               ld_valid;
    logic [7:0]         ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic               core_rst;
    logic [ADDR_W:0]    prog_len;
    logic               ld_ovf;

    modport master (
        output PC, ld_start, ld_valid, ld_data, ld_last,
        input  instr, ld_ready, core_rst, prog_len, ld_ovf
    );

    modport slave (
        input  PC, ld_start, ld_valid, ld_data, ld_last,
        output instr, ld_ready, core_rst, prog_len, ld_ovf
    );
endinterface

// File: rtl/imem_loader_rom.sv
// ---------------------------------------------------------------------------
// imem_loader_rom
// Purpose : instruction memory for fetch with an asynchronous read port, plus
//           a byte-serial valid/ready program loader. While loading, the core
//           is held in reset (core_rst low) and sees the HALT word; after the
//           final byte one RELEASE cycle follows, then the core runs from 0.
// Ports   : clk   clock, all state on posedge
//           rst   asynchronous active-low reset
//           bus   imem_loader_rom_if.slave (fetch + loader signals)
// Config  : IMEM_BOUNDS_EN - when defined, fetches at PC >= prog_len return
//           HALT in RUN; when undefined every PC reads memory.
//           INSTR_BITS / A_BITS / HALT supply default width and halt word.
// ---------------------------------------------------------------------------
`ifndef INSTR_BITS
`define INSTR_BITS 16
`endif
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef HALT
`define HALT 16'hF00F
`endif

module imem_loader_rom #(
    parameter int INSTR_W = `INSTR_BITS,
    parameter int ADDR_W  = `A_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_loader_rom_if.slave      bus
);
    localparam int BPW   = INSTR_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0]   BYTE_LAST = CNT_W'(BPW - 1);
    localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(`HALT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               state_q;
    logic                 ld_ready_q;
    logic                 core_rst_q;
    logic [ADDR_W:0]      prog_len_q;
    logic                 ld_ovf_q;
    logic [CNT_W-1:0]     byte_cnt_q;
    logic [ADDR_W:0]      wr_addr_q;   // one extra bit: DEPTH means "full"
    logic [INSTR_W-1:0]   word_q;

    // Memory powers up holding HALT and is never cleared by reset.
    logic [INSTR_W-1:0]   mem_q [DEPTH] = '{default: HALT_WORD};

    logic                 beat_s;
    logic                 word_end_s;
    logic                 room_s;
    logic                 wr_en_s;
    logic [INSTR_W+7:0]   shift_full_s;
    logic [INSTR_W-1:0]   shifted_s;
    logic [CNT_W+2:0]     pad_sh_s;
    logic [INSTR_W-1:0]   wr_data_s;
    logic [INSTR_W-1:0]   instr_s;

    // Beat qualification and word assembly for the write port.
    always_comb begin
        beat_s       = bus.ld_valid & ld_ready_q;
        word_end_s   = (byte_cnt_q == BYTE_LAST) | bus.ld_last;
        room_s       = ~wr_addr_q[ADDR_W];
        shift_full_s = {word_q, bus.ld_data};
        shifted_s    = shift_full_s[INSTR_W-1:0];
        // A short final word is left-justified so missing low bytes read as zero.
        pad_sh_s     = {BYTE_LAST - byte_cnt_q, 3'b000};
        if (bus.ld_last) begin
            wr_data_s = shifted_s << pad_sh_s;
        end else begin
            wr_data_s = shifted_s;
        end
        wr_en_s      = beat_s & word_end_s & room_s;
    end

    // Fetch read port: memory only in RUN, HALT otherwise.
    always_comb begin
        instr_s = HALT_WORD;
        if (state_q == ST_RUN) begin
`ifdef IMEM_BOUNDS_EN
            if ({1'b0, bus.PC} < prog_len_q) begin
                instr_s = mem_q[bus.PC];
            end else begin
                instr_s = HALT_WORD;
            end
`else
            instr_s = mem_q[bus.PC];
`endif
        end else begin
            instr_s = HALT_WORD;
        end
    end

    // Loader state machine with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            ld_ready_q <= 1'b0;
            core_rst_q <= 1'b1;
            prog_len_q <= '0;
            ld_ovf_q   <= 1'b0;
            byte_cnt_q <= '0;
            wr_addr_q  <= '0;
            word_q     <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.ld_start) begin
                        state_q    <= ST_LOAD;
                        ld_ready_q <= 1'b1;
                        core_rst_q <= 1'b0;
                        ld_ovf_q   <= 1'b0;
                        byte_cnt_q <= '0;
                        wr_addr_q  <= '0;
                        word_q     <= '0;
                    end else begin
                        ld_ready_q <= 1'b0;
                        core_rst_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        if (word_end_s) begin
                            byte_cnt_q <= '0;
                            word_q     <= '0;
                            if (room_s) begin
                                wr_addr_q <= wr_addr_q + (ADDR_W+1)'(1);
                            end else begin
                                ld_ovf_q  <= 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                            word_q     <= shifted_s;
                        end
                        if (bus.ld_last) begin
                            // Saturates at DEPTH because no write happens once full.
                            prog_len_q <= room_s ? (wr_addr_q + (ADDR_W+1)'(1)) : wr_addr_q;
                            state_q    <= ST_RELEASE;
                            ld_ready_q <= 1'b0;
                        end else begin
                            ld_ready_q <= 1'b1;
                        end
                    end else begin
                        ld_ready_q <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q    <= ST_RUN;
                    core_rst_q <= 1'b1;
                    ld_ready_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_RUN;
                    ld_ready_q <= 1'b0;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    // Single synchronous write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_q[ADDR_W-1:0]] <= wr_data_s;
        end
    end

    assign bus.instr    = instr_s;
    assign bus.ld_ready = ld_ready_q;
    assign bus.core_rst = core_rst_q;
    assign bus.prog_len = prog_len_q;
    assign bus.ld_ovf   = ld_ovf_q;

endmodule
